// File: rtl/line_collector.sv
`default_nettype none
// ============================================================================
// Module   : line_collector
// Purpose  : Round-robin return-path concentrator; 16 serial lines -> serOut.
//            Define LINE_COLLECTOR_PARITY_EN for a trailing even-parity bit.
// Revision : 1.0  initial release
// ============================================================================
module line_collector #(
  parameter int FRAME_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:3] lines0,
  input  logic [0:3] lines1,
  input  logic [0:3] lines2,
  input  logic [0:3] lines3,
  output logic [0:3] ack0,
  output logic [0:3] ack1,
  output logic [0:3] ack2,
  output logic [0:3] ack3,
  output logic       serOut,
  output logic       valid,
  output logic [3:0] PB,
  output logic [0:1] LB,
  output logic       busy,
  output logic       frame_done
`ifdef LINE_COLLECTOR_PARITY_EN
  ,
  output logic       parity_err
`endif
);

`ifdef LINE_COLLECTOR_PARITY_EN
  localparam int c_samples = FRAME_BITS + 1;
`else
  localparam int c_samples = FRAME_BITS;
`endif
  localparam logic [5:0] c_last_sample = 6'(c_samples - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_rr_ptr;
  logic [3:0]  r_sel;
  logic [5:0]  r_cnt;
  logic [15:0] r_ack;
  logic        r_ser;
  logic        r_valid;
  logic [3:0]  r_pb;
  logic [1:0]  r_lb;
  logic        r_busy;
  logic        r_done;
`ifdef LINE_COLLECTOR_PARITY_EN
  logic        r_par;
  logic        r_perr;
`endif

  logic [15:0] w_req;
  logic [3:0]  w_scan_idx;
  logic [3:0]  w_grant_idx;
  logic        w_grant_any;
  logic        w_sel_bit;

  // Flat index = 4*port + line, for both requests and acks.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      assign w_req[gi]      = lines0[gi];
      assign w_req[4 + gi]  = lines1[gi];
      assign w_req[8 + gi]  = lines2[gi];
      assign w_req[12 + gi] = lines3[gi];
      assign ack0[gi]       = r_ack[gi];
      assign ack1[gi]       = r_ack[4 + gi];
      assign ack2[gi]       = r_ack[8 + gi];
      assign ack3[gi]       = r_ack[12 + gi];
    end
  endgenerate

  assign w_sel_bit  = w_req[r_sel];
  assign serOut     = r_ser;
  assign valid      = r_valid;
  assign PB         = r_pb;
  assign LB         = r_lb;
  assign busy       = r_busy;
  assign frame_done = r_done;
`ifdef LINE_COLLECTOR_PARITY_EN
  assign parity_err = r_perr;
`endif

  // First requester at or after the round-robin pointer, wrapping mod 16.
  always_comb begin
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    w_scan_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      w_scan_idx = r_rr_ptr + 4'(i);
      if (!w_grant_any && w_req[w_scan_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan_idx;
      end
    end
  end

  // Line code is Gray-ordered so it matches the broadcaster's addressing.
  function automatic logic [1:0] lb_code(input logic [1:0] line);
    case (line)
      2'd0:    lb_code = 2'b00;
      2'd1:    lb_code = 2'b01;
      2'd2:    lb_code = 2'b11;
      default: lb_code = 2'b10;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_ser    <= 1'b0;
      r_valid  <= 1'b0;
      r_pb     <= '0;
      r_lb     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef LINE_COLLECTOR_PARITY_EN
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          r_busy  <= w_grant_any;
          if (w_grant_any) begin
            r_sel    <= w_grant_idx;
            r_rr_ptr <= w_grant_idx + 4'd1;
            r_ack    <= 16'd1 << w_grant_idx;
            r_pb     <= 4'd1 << w_grant_idx[3:2];
            r_lb     <= lb_code(w_grant_idx[1:0]);
`ifdef LINE_COLLECTOR_PARITY_EN
            r_perr   <= 1'b0;
`endif
            r_state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_ack   <= '0;
          r_cnt   <= '0;
`ifdef LINE_COLLECTOR_PARITY_EN
          r_par   <= 1'b0;
`endif
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_cnt <= r_cnt + 6'd1;
`ifdef LINE_COLLECTOR_PARITY_EN
          if (r_cnt == c_last_sample) begin
            // Parity sample: not a data bit, so valid drops here.
            r_valid <= 1'b0;
            r_perr  <= r_par ^ w_sel_bit;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_ser   <= w_sel_bit;
            r_valid <= 1'b1;
            r_par   <= r_par ^ w_sel_bit;
          end
`else
          r_ser   <= w_sel_bit;
          r_valid <= 1'b1;
          if (r_cnt == c_last_sample) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_collector
// Purpose  : Self-checking bench for line_collector with protocol-following
//            senders and a round-robin reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_line_collector;
  localparam int FB = 8;
`ifdef LINE_COLLECTOR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam logic [31:0] MASK = 32'((64'd1 << FB) - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:3] lines0 = '0, lines1 = '0, lines2 = '0, lines3 = '0;
  logic [0:3] ack0, ack1, ack2, ack3;
  logic serOut, valid, busy, frame_done;
  logic [3:0] PB;
  logic [0:1] LB;
`ifdef LINE_COLLECTOR_PARITY_EN
  logic parity_err;
`endif

  line_collector #(.FRAME_BITS(FB)) dut (
    .clk(clk), .rst(rst),
    .lines0(lines0), .lines1(lines1), .lines2(lines2), .lines3(lines3),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .serOut(serOut), .valid(valid), .PB(PB), .LB(LB),
    .busy(busy), .frame_done(frame_done)
`ifdef LINE_COLLECTOR_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Sender state: 0 idle, 1 requesting, 2 ack seen, 3 sending, 4 resting.
  int          snd_st[16];
  int          snd_cnt[16];
  logic [31:0] snd_data[16];
  bit          snd_bad[16];
  bit          snd_repeat[16];
  bit          drv[16];

  // Reference model
  int          m_ptr, m_occ, m_last;
  logic [31:0] m_frame;
  bit          m_bad, m_perr;
  logic [1:0]  lb_tab[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // Observed traffic
  int          grant_log[$];
  logic [31:0] rx_log[$];
  logic [31:0] rx_word;
  int          cur_bits;

  function automatic bit tx_bit(int i, int k);
    if (k < FB) return snd_data[i][FB-1-k];
    return (^(snd_data[i] & MASK)) ^ snd_bad[i];
  endfunction

  task automatic apply_lines();
    for (int l = 0; l < 4; l++) begin
      lines0[l] = drv[l];
      lines1[l] = drv[4+l];
      lines2[l] = drv[8+l];
      lines3[l] = drv[12+l];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_occ = 0; m_last = -1; m_perr = 0;
    rx_word = '0; cur_bits = 0;
  endtask

  task automatic start_req(int i, logic [31:0] data, bit bad);
    snd_data[i] = data & MASK;
    snd_bad[i]  = bad;
    snd_st[i]   = 1;
    drv[i]      = 1'b1;
    apply_lines();
  endtask

  // One clock: observe at negedge, compare to model, then advance senders.
  task automatic tick();
    logic [15:0] ackv, reqv, exp_ack;
    logic [3:0]  exp_pb;
    logic [1:0]  exp_lb;
    bit          exp_valid, exp_done, exp_busy, exp_bit, found;
    int          k, g;
    @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      ackv[l] = ack0[l]; ackv[4+l] = ack1[l]; ackv[8+l] = ack2[l]; ackv[12+l] = ack3[l];
    end
    for (int i = 0; i < 16; i++) reqv[i] = drv[i];
    if (rst) begin
      n_checks++;
      if (ackv !== '0 || serOut !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 ||
          frame_done !== 1'b0 || PB !== 4'b0 || LB !== 2'b0) begin
        n_fail++;
        $display("FAIL reset_hold: ack=%h ser=%b valid=%b busy=%b done=%b PB=%b LB=%b, required all 0",
                 ackv, serOut, valid, busy, frame_done, PB, LB);
      end
    end else begin
      exp_ack = '0; exp_valid = 0; exp_done = 0; exp_busy = 0; exp_bit = 0;
      if (m_occ > 0) begin
        m_occ--;
        k = FB + 1 + PAR - m_occ;
        exp_busy  = 1;
        exp_valid = (k >= 2) && (k <= FB + 1);
        exp_done  = (m_occ == 0);
        if (exp_valid) exp_bit = m_frame[FB-1-(k-2)];
        if (exp_done) m_perr = m_bad;
      end else begin
        found = 0; g = 0;
        for (int d = 0; d < 16; d++)
          if (!found && reqv[(m_ptr + d) % 16]) begin found = 1; g = (m_ptr + d) % 16; end
        if (found) begin
          exp_ack  = 16'd1 << g;
          exp_busy = 1;
          m_last   = g;
          m_ptr    = (g + 1) % 16;
          m_occ    = FB + 1 + PAR;
          m_frame  = snd_data[g];
          m_bad    = snd_bad[g];
          m_perr   = 0;
        end
      end
      exp_pb = (m_last < 0) ? 4'b0 : (4'b0001 << (m_last / 4));
      exp_lb = (m_last < 0) ? 2'b00 : lb_tab[m_last % 4];
      n_checks++;
      if ({ackv, valid, busy, frame_done} !== {exp_ack, exp_valid, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL ctrl @%0t: ack=%h valid=%b busy=%b done=%b, required ack=%h valid=%b busy=%b done=%b",
                 $time, ackv, valid, busy, frame_done, exp_ack, exp_valid, exp_busy, exp_done);
      end
      n_checks++;
      if ({PB, LB} !== {exp_pb, exp_lb}) begin
        n_fail++;
        $display("FAIL addr @%0t: PB=%b LB=%b, required PB=%b LB=%b", $time, PB, LB, exp_pb, exp_lb);
      end
      if (exp_valid) begin
        n_checks++;
        if (serOut !== exp_bit) begin
          n_fail++;
          $display("FAIL serOut @%0t: got %b, required %b", $time, serOut, exp_bit);
        end
      end
`ifdef LINE_COLLECTOR_PARITY_EN
      n_checks++;
      if (parity_err !== m_perr) begin
        n_fail++;
        $display("FAIL parity_err @%0t: got %b, required %b", $time, parity_err, m_perr);
      end
`endif
      for (int i = 0; i < 16; i++) if (ackv[i]) begin grant_log.push_back(i); rx_word = '0; cur_bits = 0; end
      if (valid === 1'b1) begin rx_word = {rx_word[30:0], serOut}; cur_bits++; end
      if (frame_done === 1'b1) begin rx_log.push_back(rx_word); rx_word = '0; cur_bits = 0; end
    end
    for (int i = 0; i < 16; i++) begin
      case (snd_st[i])
        1: begin drv[i] = 1'b1; if (ackv[i]) snd_st[i] = 2; end
        2: begin drv[i] = tx_bit(i, 0); snd_cnt[i] = 1; snd_st[i] = 3; end
        3: begin
          if (snd_cnt[i] == FB + PAR) begin drv[i] = 1'b0; snd_st[i] = 4; end
          else begin drv[i] = tx_bit(i, snd_cnt[i]); snd_cnt[i]++; end
        end
        4: begin
          if (snd_repeat[i]) begin
            snd_data[i] = $urandom & MASK; snd_bad[i] = 0; snd_st[i] = 1; drv[i] = 1'b1;
          end else begin
            snd_st[i] = 0; drv[i] = 1'b0;
          end
        end
        default: drv[i] = 1'b0;
      endcase
    end
    apply_lines();
  endtask

  task automatic run_until_frames(int n, int budget, output bit ok);
    int c = 0;
    ok = 1;
    while (rx_log.size() < n) begin
      if (c >= budget) begin ok = 0; break; end
      tick(); c++;
    end
  endtask

  task automatic run_until_quiet(int budget, output bit ok);
    bit active;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      active = (m_occ > 0);
      for (int i = 0; i < 16; i++) if (snd_st[i] != 0) active = 1;
      if (!active) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin snd_st[i] = 0; snd_repeat[i] = 0; drv[i] = 0; end
    apply_lines();
    model_reset();
    tick(); tick();
    rst = 1'b0;
    grant_log.delete();
    rx_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || PB !== 4'b0 || LB !== 2'b0 || grant_log.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b valid=%b PB=%b LB=%b grants=%0d, required 0", busy, valid, PB, LB, grant_log.size());
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    start_req(6, 32'hA5, 0);
    run_until_frames(1, 40, ok);
    n_checks++;
    if (!ok || grant_log.size() != 1 || grant_log[0] != 6 || rx_log[0] !== 32'hA5) begin
      n_fail++;
      $display("FAIL single_frame: ok=%b grants=%0d rx=%h, required line 6 frame a5", ok, grant_log.size(),
               (rx_log.size() > 0) ? rx_log[0] : 32'hx);
    end
    tick();
    n_checks++;
    if (PB !== 4'b0010 || LB !== 2'b11) begin
      n_fail++;
      $display("FAIL single_addr_hold: PB=%b LB=%b, required PB=0010 LB=11", PB, LB);
    end
    run_until_quiet(20, ok);
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] d0, d11, d13;
    do_reset();
    d0 = $urandom & MASK; d11 = $urandom & MASK; d13 = $urandom & MASK;
    start_req(0, d0, 0); start_req(11, d11, 0); start_req(13, d13, 0);
    run_until_frames(3, 100, ok);
    n_checks++;
    if (!ok || grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 11 || grant_log[2] != 13) begin
      n_fail++;
      $display("FAIL rr_order: ok=%b grants=%0d, required order 0,11,13", ok, grant_log.size());
    end
    n_checks++;
    if (rx_log.size() != 3 || rx_log[0] !== d0 || rx_log[1] !== d11 || rx_log[2] !== d13) begin
      n_fail++;
      $display("FAIL rr_data: frames=%0d, required %h %h %h", rx_log.size(), d0, d11, d13);
    end
    run_until_quiet(30, ok);
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    start_req(5, $urandom, 0);
    snd_repeat[5] = 1;
    repeat (4) tick();
    start_req(9, $urandom, 0);
    start_req(2, $urandom, 0);
    run_until_frames(4, 120, ok);
    snd_repeat[5] = 0;
    n_checks++;
    if (!ok || grant_log.size() < 4 || grant_log[0] != 5 || grant_log[1] != 9 ||
        grant_log[2] != 2 || grant_log[3] != 5) begin
      n_fail++;
      $display("FAIL fairness: ok=%b grants=%0d, required order 5,9,2,5", ok, grant_log.size());
    end
    run_until_quiet(40, ok);
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int c;
    do_reset();
    start_req(2, $urandom, 0);
    c = 0;
    while (cur_bits < 3 && c < 40) begin tick(); c++; end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (cur_bits != 3 || busy !== 1'b0 || valid !== 1'b0 || frame_done !== 1'b0 || PB !== 4'b0 ||
        LB !== 2'b0 || {ack0, ack1, ack2, ack3} !== 16'b0 || serOut !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: bits=%0d busy=%b valid=%b done=%b PB=%b LB=%b ser=%b, required 3 bits then all 0",
               cur_bits, busy, valid, frame_done, PB, LB, serOut);
    end
    model_reset();
    c = 0;
    while (snd_st[2] != 0 && c < 40) begin tick(); c++; end
    start_req(2, $urandom, 0);
    start_req(14, $urandom, 0);
    tick();
    rst = 1'b0;
    run_until_frames(2, 60, ok);
    n_checks++;
    if (!ok || rx_log.size() != 2 || grant_log.size() != 3 || grant_log[1] != 2 || grant_log[2] != 14) begin
      n_fail++;
      $display("FAIL reset_rr_ptr: ok=%b frames=%0d grants=%0d, required frames 2 order 2,14", ok, rx_log.size(), grant_log.size());
    end
    run_until_quiet(30, ok);
  endtask

  task automatic test_random();
    bit ok;
    int started = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 16; i++)
        if (snd_st[i] == 0 && $urandom_range(24, 0) == 0) begin
          start_req(i, $urandom, PAR ? ($urandom_range(3, 0) == 0) : 1'b0);
          started++;
        end
      tick();
    end
    run_until_quiet(16 * (FB + 4) + 20, ok);
    n_checks++;
    if (!ok || rx_log.size() != started) begin
      n_fail++;
      $display("FAIL random_frames: ok=%b forwarded=%0d, required %0d", ok, rx_log.size(), started);
    end
  endtask

`ifdef LINE_COLLECTOR_PARITY_EN
  task automatic test_parity();
    bit ok;
    do_reset();
    start_req(7, 32'h0F, 0);
    run_until_frames(1, 40, ok);
    n_checks++;
    if (!ok || parity_err !== 1'b0 || rx_log[0] !== 32'h0F) begin
      n_fail++;
      $display("FAIL parity_good: ok=%b parity_err=%b, required 0", ok, parity_err);
    end
    run_until_quiet(20, ok);
    start_req(7, 32'h0F, 1);
    run_until_frames(2, 40, ok);
    n_checks++;
    if (!ok || parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_bad: ok=%b parity_err=%b, required 1", ok, parity_err);
    end
    repeat (3) tick();
    n_checks++;
    if (parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_hold: parity_err=%b, required 1", parity_err);
    end
    run_until_quiet(20, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_reset_midframe();
`ifdef LINE_COLLECTOR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
